// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and constants for the pipeline control block
package riscv_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int X0_ADDR    = 0;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MDU_WAIT = 2'd2,
    MEM_WAIT = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use comparator between the D-stage sources and the M-stage load
module hazard_detect
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_is_load,
  input  logic              m_reg_we,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = d_use_rs1 && (d_rs1 == m_rd);
  assign rs2_hit  = d_use_rs2 && (d_rs2 == m_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = m_is_load && m_reg_we && (m_rd != REG_AW'(X0_ADDR)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer for the F->D->M pipeline with stall counter
module pipe_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic              d_br_taken,
  input  logic              d_mdu_start,
  input  logic              mdu_done,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_is_load,
  input  logic              m_reg_we,
  input  logic              m_mem_req,
  input  logic              m_mem_ack,
  output logic              pc_ce,
  output logic              s1_ce,
  output logic              s1_flush,
  output logic              s2_ce,
  output logic              s2_flush,
  output logic              mdu_busy,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  ctrl_state_e      state_q, state_d;
  logic [BW-1:0]    boot_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;
  logic             mem_stall;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .d_rs1     (d_rs1),
    .d_rs2     (d_rs2),
    .d_use_rs1 (d_use_rs1),
    .d_use_rs2 (d_use_rs2),
    .m_rd      (m_rd),
    .m_is_load (m_is_load),
    .m_reg_we  (m_reg_we),
    .load_use  (load_use)
  );

  assign mem_stall = m_mem_req && !m_mem_ack;

  always_comb begin
    pc_ce    = 1'b1;
    s1_ce    = 1'b1;
    s1_flush = 1'b0;
    s2_ce    = 1'b1;
    s2_flush = 1'b0;
    mdu_busy = 1'b0;
    state_d  = state_q;
    if (rst || state_q == BOOT) begin
      pc_ce    = 1'b0;
      s1_ce    = 1'b0;
      s2_ce    = 1'b0;
      s1_flush = 1'b1;
      s2_flush = 1'b1;
      if (rst) begin
        state_d = BOOT;
      end else if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            pc_ce   = 1'b0;
            s1_ce   = 1'b0;
            s2_ce   = 1'b0;
            state_d = MEM_WAIT;
          end else if (d_mdu_start || load_use) begin
            // both hold F/D and push one bubble into M; only the MDU waits for completion
            pc_ce    = 1'b0;
            s1_ce    = 1'b0;
            s2_flush = 1'b1;
            if (d_mdu_start) state_d = MDU_WAIT;
          end else if (d_br_taken) begin
            s1_ce    = 1'b0;
            s1_flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          mdu_busy = 1'b1;
          if (mdu_done) begin
            state_d = RUN;
          end else begin
            pc_ce    = 1'b0;
            s1_ce    = 1'b0;
            s2_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (m_mem_ack) begin
            state_d = RUN;
          end else begin
            pc_ce = 1'b0;
            s1_ce = 1'b0;
            s2_ce = 1'b0;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BOOT && boot_cnt_q != BW'(BOOT_CYCLES - 1)) begin
        boot_cnt_q <= boot_cnt_q + 1'b1;
      end
      if (state_q != BOOT && !pc_ce && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with a 4-bit counter twin
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [4:0] d_rs1 = '0, d_rs2 = '0, m_rd = '0;
  logic       d_use_rs1 = 0, d_use_rs2 = 0, d_br_taken = 0, d_mdu_start = 0, mdu_done = 0;
  logic       m_is_load = 0, m_reg_we = 0, m_mem_req = 0, m_mem_ack = 0;

  logic        pc_ce, s1_ce, s1_flush, s2_ce, s2_flush, mdu_busy;
  logic [1:0]  state;
  logic [31:0] stall_cnt;
  logic        pc_ce4, s1_ce4, s1_flush4, s2_ce4, s2_flush4, mdu_busy4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .d_br_taken(d_br_taken), .d_mdu_start(d_mdu_start), .mdu_done(mdu_done), .m_rd(m_rd),
    .m_is_load(m_is_load), .m_reg_we(m_reg_we), .m_mem_req(m_mem_req), .m_mem_ack(m_mem_ack),
    .pc_ce(pc_ce), .s1_ce(s1_ce), .s1_flush(s1_flush), .s2_ce(s2_ce), .s2_flush(s2_flush),
    .mdu_busy(mdu_busy), .state(state), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .d_br_taken(d_br_taken), .d_mdu_start(d_mdu_start), .mdu_done(mdu_done), .m_rd(m_rd),
    .m_is_load(m_is_load), .m_reg_we(m_reg_we), .m_mem_req(m_mem_req), .m_mem_ack(m_mem_ack),
    .pc_ce(pc_ce4), .s1_ce(s1_ce4), .s1_flush(s1_flush4), .s2_ce(s2_ce4), .s2_flush(s2_flush4),
    .mdu_busy(mdu_busy4), .state(state4), .stall_cnt(stall_cnt4)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       use1, use2, br, mstart, mdone;
    logic [4:0] rd;
    logic       ld, we, req, ack;
  } stim_t;

  typedef struct {
    logic [7:0]  v;
    logic [7:0]  m;
    int unsigned st;
  } exp_t;

  // {pc_ce, s1_ce, s1_flush, s2_ce, s2_flush, mdu_busy, state[1:0]}
  localparam logic [7:0] BOOTV   = 8'b0010_1000;
  localparam logic [7:0] RUNV    = 8'b1101_0001;
  localparam logic [7:0] LUV     = 8'b0001_1001;
  localparam logic [7:0] MDUW    = 8'b0001_1110;
  localparam logic [7:0] MDUDONE = 8'b1101_0110;
  localparam logic [7:0] FRZ_RUN = 8'b0000_0001;
  localparam logic [7:0] FRZ_MEM = 8'b0000_0011;
  localparam logic [7:0] ACK_MEM = 8'b1101_0011;
  localparam logic [7:0] BRV     = 8'b1011_0001;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_stall = 0;

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t st_rst();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t st_lu(input logic [4:0] rd);
    stim_t s = '0;
    s.ld = 1'b1; s.we = 1'b1; s.rd = rd; s.use2 = 1'b1; s.rs2 = rd;
    return s;
  endfunction

  function automatic logic [7:0] got();
    return {pc_ce, s1_ce, s1_flush, s2_ce, s2_flush, mdu_busy, state};
  endfunction

  function automatic logic [3:0] sat4(input int unsigned x);
    return (x > 15) ? 4'hF : x[3:0];
  endfunction

  task automatic drive(input stim_t s, input logic [7:0] v);
    exp_t e;
    rst = s.rst; d_rs1 = s.rs1; d_rs2 = s.rs2; d_use_rs1 = s.use1; d_use_rs2 = s.use2;
    d_br_taken = s.br; d_mdu_start = s.mstart; mdu_done = s.mdone; m_rd = s.rd;
    m_is_load = s.ld; m_reg_we = s.we; m_mem_req = s.req; m_mem_ack = s.ack;
    e.v = v; e.m = s.rst ? 8'hFC : 8'hFF; e.st = exp_stall;
    sbq.push_back(e);
    if (s.rst) exp_stall = 0;
    else if (v[1:0] != 2'd0 && !v[7]) exp_stall++;
  endtask

  task automatic test_reset();
    stim_t ss[$];
    logic [7:0] vv[$];
    exp_t w;
    rst = 1'b1;
    @(posedge clk); #1;
    ss = '{st_rst(), idle(), idle(), idle()};
    vv = '{BOOTV, BOOTV, BOOTV, RUNV};
    foreach (ss[i]) begin
      drive(ss[i], vv[i]);
      @(negedge clk); w = sbq.pop_front();
      checks++; if ((got() & w.m) !== (w.v & w.m)) begin errors++; $display("FAIL reset step %0d: outputs got %b want %b", i, got(), w.v); end
      checks++; if (stall_cnt !== w.st) begin errors++; $display("FAIL reset step %0d: stall_cnt got %0d want %0d", i, stall_cnt, w.st); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t ss[$];
    logic [7:0] vv[$];
    stim_t a, b;
    exp_t w;
    a = st_lu(5'd5); a.use2 = 1'b0;
    b = st_lu(5'd5); b.use2 = 1'b0; b.use1 = 1'b1; b.rs1 = 5'd5; b.rs2 = 5'd0;
    ss = '{st_lu(5'd5), idle(), st_lu(5'd0), a, b, idle()};
    vv = '{LUV, RUNV, RUNV, RUNV, LUV, RUNV};
    foreach (ss[i]) begin
      drive(ss[i], vv[i]);
      @(negedge clk); w = sbq.pop_front();
      checks++; if (got() !== w.v) begin errors++; $display("FAIL load_use step %0d: outputs got %b want %b", i, got(), w.v); end
      checks++; if (stall_cnt !== w.st) begin errors++; $display("FAIL load_use step %0d: stall_cnt got %0d want %0d", i, stall_cnt, w.st); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mdu();
    stim_t ss[$];
    logic [7:0] vv[$];
    stim_t st, dn;
    exp_t w;
    st = idle(); st.mstart = 1'b1;
    dn = idle(); dn.mdone = 1'b1;
    ss = '{st, idle(), st, idle(), dn, idle(), dn, idle()};
    vv = '{LUV, MDUW, MDUW, MDUW, MDUDONE, RUNV, RUNV, RUNV};
    foreach (ss[i]) begin
      drive(ss[i], vv[i]);
      @(negedge clk); w = sbq.pop_front();
      checks++; if (got() !== w.v) begin errors++; $display("FAIL mdu step %0d: outputs got %b want %b", i, got(), w.v); end
      checks++; if (stall_cnt !== w.st) begin errors++; $display("FAIL mdu step %0d: stall_cnt got %0d want %0d", i, stall_cnt, w.st); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_priority();
    stim_t ss[$];
    logic [7:0] vv[$];
    stim_t h, ha, lb, br, ra;
    exp_t w;
    h  = st_lu(5'd5); h.br = 1'b1; h.req = 1'b1;
    ha = h; ha.ack = 1'b1;
    lb = st_lu(5'd5); lb.br = 1'b1;
    br = idle(); br.br = 1'b1;
    ra = idle(); ra.req = 1'b1; ra.ack = 1'b1;
    ss = '{h, h, h, ha, lb, br, idle(), ra, idle()};
    vv = '{FRZ_RUN, FRZ_MEM, FRZ_MEM, ACK_MEM, LUV, BRV, RUNV, RUNV, RUNV};
    foreach (ss[i]) begin
      drive(ss[i], vv[i]);
      @(negedge clk); w = sbq.pop_front();
      checks++; if (got() !== w.v) begin errors++; $display("FAIL mem_priority step %0d: outputs got %b want %b", i, got(), w.v); end
      checks++; if (stall_cnt !== w.st) begin errors++; $display("FAIL mem_priority step %0d: stall_cnt got %0d want %0d", i, stall_cnt, w.st); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_in_mdu();
    stim_t ss[$];
    logic [7:0] vv[$];
    stim_t st, dn;
    exp_t w;
    st = idle(); st.mstart = 1'b1;
    dn = idle(); dn.mdone = 1'b1;
    ss = '{st, idle(), idle(), st_rst(), dn, dn, idle(), idle()};
    vv = '{LUV, MDUW, MDUW, BOOTV, BOOTV, BOOTV, RUNV, RUNV};
    foreach (ss[i]) begin
      drive(ss[i], vv[i]);
      @(negedge clk); w = sbq.pop_front();
      checks++; if ((got() & w.m) !== (w.v & w.m)) begin errors++; $display("FAIL rst_in_mdu step %0d: outputs got %b want %b", i, got(), w.v); end
      checks++; if (stall_cnt !== w.st) begin errors++; $display("FAIL rst_in_mdu step %0d: stall_cnt got %0d want %0d", i, stall_cnt, w.st); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    stim_t ss[$];
    logic [7:0] vv[$];
    exp_t w;
    ss = '{st_rst(), idle(), idle()};
    vv = '{BOOTV, BOOTV, BOOTV};
    for (int k = 0; k < 20; k++) begin
      ss.push_back(st_lu(5'd7));
      vv.push_back(LUV);
    end
    ss.push_back(idle());
    vv.push_back(RUNV);
    foreach (ss[i]) begin
      drive(ss[i], vv[i]);
      @(negedge clk); w = sbq.pop_front();
      checks++; if ((got() & w.m) !== (w.v & w.m)) begin errors++; $display("FAIL saturate step %0d: outputs got %b want %b", i, got(), w.v); end
      checks++; if (stall_cnt4 !== sat4(w.st)) begin errors++; $display("FAIL saturate step %0d: stall_cnt4 got %0d want %0d", i, stall_cnt4, sat4(w.st)); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt4 !== 4'hF) begin errors++; $display("FAIL saturate final: stall_cnt4 got %0d want 15", stall_cnt4); end
    checks++; if (stall_cnt !== 32'd20) begin errors++; $display("FAIL saturate final: stall_cnt got %0d want 20", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_mem_priority();
    test_rst_in_mdu();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
